register_banks: RTL and testbench
=================================

REGISTER_BANKS -- requirements
Module: register_banks

Interface
REQ-001 Parameter DATA_W, default 8, width of one register and of uart_data.
REQ-002 Parameter NUM_BANKS, default 4, number of register banks (1..16).
REQ-003 Parameter BANK_REGS, default 4, registers per bank, power of two (2..16).
REQ-004 Derived constants SHALL be NUM_REGS = NUM_BANKS*BANK_REGS and ADDR_W = max(1, clog2(NUM_REGS)).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 uart_addr  in  ADDR_W  register address of inbound byte.
REQ-008 uart_data  in  DATA_W  inbound byte.
REQ-009 uart_ready  in  1  level, data valid; rising edge = one write.
REQ-010 stream_mode  in  1  1 = internal auto-increment pointer replaces uart_addr.
REQ-011 rd_addr  in  ADDR_W  readback address.
REQ-012 rd_data  out  DATA_W  registered readback of live register rd_addr.
REQ-013 reg_data  out  NUM_REGS*DATA_W  flattened live registers; register i at bits [DATA_W*i +: DATA_W].
REQ-014 reg_event  out  NUM_BANKS  one-cycle commit pulse per bank.
REQ-015 addr_error  out  1  one-cycle pulse on write to address >= NUM_REGS.

Function
REQ-016 Write strobe SHALL assert for exactly one cycle, the cycle after the first clk edge at which uart_ready is sampled high following a sampled low; a held-high ready produces one strobe.
REQ-017 Effective address SHALL be ptr when stream_mode = 1, else uart_addr, both sampled in the strobe cycle.
REQ-018 On strobe with valid address, the byte SHALL be written into the staging array at that edge.
REQ-019 Writes to non-top registers of a bank SHALL NOT alter reg_data.
REQ-020 Write to the top register (addr mod BANK_REGS = BANK_REGS-1) SHALL copy the whole bank from staging, including the new byte, into live reg_data at the same edge.
REQ-021 reg_event bit addr/BANK_REGS SHALL pulse high for the cycle following that commit edge; all other bits low.
REQ-022 Out-of-range write: no staging, live or ptr-increment effect; addr_error pulses the following cycle.
REQ-023 ptr SHALL be held at 0 while stream_mode = 0; in stream mode it SHALL increment after each strobe, wrapping NUM_REGS-1 -> 0.
REQ-024 rd_data SHALL equal live register rd_addr one cycle after rd_addr is presented; it returns 0 for out-of-range rd_addr.
REQ-025 Readback of a register committed at edge k SHALL return the new value at edge k+1 if rd_addr is stable.
REQ-026 uart_addr, uart_data, rd_addr and stream_mode SHALL have no effect outside strobe and readback cycles.

Reset
REQ-027 While reset is high: staging, reg_data, rd_data, ptr and history flops SHALL be 0; reg_event SHALL be all ones (clear all sound modules); addr_error SHALL be 0.
REQ-028 On the first clk edge after reset release, reg_event SHALL return to 0.
REQ-029 uart_ready high at reset release SHALL NOT produce a strobe.
REQ-030 Reset mid-bank SHALL discard partial staging; no commit follows.

Structure
REQ-031 The shared package registers_pkg SHALL hold default parameter values and the clog2-based ADDR_W function.
REQ-032 Sub-module ready_edge (history flops plus rising-edge strobe) SHALL be instantiated once.

Verification
REQ-033 Defaults; write bank 1 addrs 4,5,6 = 11,22,33h -> reg_data unchanged; write addr 7 = 44h -> bytes 4..7 = 11,22,33,44h next cycle; reg_event = 0010b for one cycle.
REQ-034 stream_mode = 1, 17 writes of 01h..11h -> bank events 0001,0010,0100,1000b in order; ptr wraps; register 0 staged 11h, live stays 01h.
REQ-035 NUM_BANKS = 3, write addr 13 -> addr_error pulse; reg_data and ptr unchanged.
REQ-036 uart_ready held high 20 cycles -> one strobe, one write.
REQ-037 Assert reset after writes to addrs 8,9 -> reg_event = 1111b during reset, 0000b after the first post-release edge; reg_data = 0; later write to addr 11 commits 0 for addrs 8..10.
REQ-038 rd_addr = 7 across the commit in REQ-033 -> rd_data = 00h, then 44h one cycle after the commit.

Source files
------------

// File: rtl/registers_pkg.sv
// Shared defaults and address-width helper for the register bank block.
package registers_pkg;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_NUM_BANKS = 4;
    localparam int DEFAULT_BANK_REGS = 4;

    // Address width never collapses to zero, even for a two-register file.
    function automatic int addr_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/ready_edge.sv
// Turns the level uart_ready into a single-cycle write strobe on its rising edge.
module ready_edge (
    input  logic clk,
    input  logic reset,
    input  logic ready,
    output logic strobe
);

    logic ready_q;
    logic armed_q;

    // NOTE: armed_q keeps a ready already high at reset release from looking like a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            armed_q <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            ready_q <= ready;
            armed_q <= 1'b1;
            strobe  <= ready & ~ready_q & armed_q;
        end
    end

endmodule

// File: rtl/register_banks.sv
// Banked register file fed by a UART byte stream: bytes are staged per bank and
// the whole bank becomes live atomically when its top register is written.
module register_banks
    import registers_pkg::*;
#(
    parameter  int DATA_W    = DEFAULT_DATA_W,
    parameter  int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter  int BANK_REGS = DEFAULT_BANK_REGS,
    localparam int NUM_REGS  = NUM_BANKS * BANK_REGS,
    localparam int ADDR_W    = addr_width(NUM_BANKS * BANK_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          uart_addr,
    input  logic [DATA_W-1:0]          uart_data,
    input  logic                       uart_ready,
    input  logic                       stream_mode,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [NUM_BANKS-1:0]       reg_event,
    output logic                       addr_error
);

    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

    logic                 strobe;
    logic [ADDR_W-1:0]    ptr;
    logic [ADDR_W-1:0]    eff_addr;
    logic                 addr_ok;
    logic                 rd_ok;
    logic                 wr_en;
    logic                 wr_top;
    int                   wr_idx;
    int                   wr_bank;
    logic [NUM_BANKS-1:0] evt_next;
    logic [DATA_W-1:0]    live [NUM_REGS];

    ready_edge u_ready_edge (
        .clk    (clk),
        .reset  (reset),
        .ready  (uart_ready),
        .strobe (strobe)
    );

    assign eff_addr = stream_mode ? ptr : uart_addr;
    assign addr_ok  = {1'b0, eff_addr} < REG_LIMIT;
    assign rd_ok    = {1'b0, rd_addr} < REG_LIMIT;
    assign wr_en    = strobe & addr_ok;
    assign wr_idx   = int'(eff_addr);
    assign wr_bank  = wr_idx / BANK_REGS;
    assign wr_top   = (wr_idx % BANK_REGS) == (BANK_REGS - 1);

    for (genvar j = 0; j < NUM_REGS; j++) begin : g_reg
        localparam int BANK = j / BANK_REGS;
        logic [DATA_W-1:0] stage_q;
        logic [DATA_W-1:0] live_q;

        // NOTE: the register file is reset so a partially staged bank cannot leak into a later commit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
                live_q  <= '0;
            end else if (wr_en) begin
                if (wr_idx == j)
                    stage_q <= uart_data;
                // The incoming byte bypasses staging so the commit includes it.
                if (wr_top && wr_bank == BANK)
                    live_q <= (wr_idx == j) ? uart_data : stage_q;
            end
        end

        assign live[j]                      = live_q;
        assign reg_data[DATA_W*j +: DATA_W] = live_q;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_evt
        assign evt_next[b] = wr_en && wr_top && (wr_bank == b);
    end

    // Reset drives reg_event high so every downstream consumer clears at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            reg_event  <= '1;
            addr_error <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (!stream_mode)
                ptr <= '0;
            else if (strobe)
                ptr <= (ptr == LAST_REG) ? '0 : ptr + ADDR_W'(1);
            reg_event  <= evt_next;
            addr_error <= strobe & ~addr_ok;
            rd_data    <= rd_ok ? live[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_register_banks.sv
// Randomized self-checking bench for register_banks against a bank/staging reference model.
module tb_register_banks;
    import registers_pkg::*;

    localparam int AW   = 4;
    localparam int NR_A = 16;
    localparam int NR_B = 12;
    localparam int BR   = DEFAULT_BANK_REGS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0]     a_addr, b_addr, a_rd, b_rd;
    logic [7:0]        a_data, b_data, a_rdd, b_rdd;
    logic              a_rdy, b_rdy, a_stream, b_stream, a_err, b_err;
    logic [NR_A*8-1:0] a_reg;
    logic [NR_B*8-1:0] b_reg;
    logic [3:0]        a_evt;
    logic [2:0]        b_evt;

    register_banks #(.DATA_W(8), .NUM_BANKS(4), .BANK_REGS(4)) dut_a (
        .clk(clk), .reset(reset), .uart_addr(a_addr), .uart_data(a_data),
        .uart_ready(a_rdy), .stream_mode(a_stream), .rd_addr(a_rd), .rd_data(a_rdd),
        .reg_data(a_reg), .reg_event(a_evt), .addr_error(a_err)
    );

    register_banks #(.DATA_W(8), .NUM_BANKS(3), .BANK_REGS(4)) dut_b (
        .clk(clk), .reset(reset), .uart_addr(b_addr), .uart_data(b_data),
        .uart_ready(b_rdy), .stream_mode(b_stream), .rd_addr(b_rd), .rd_data(b_rdd),
        .reg_data(b_reg), .reg_event(b_evt), .addr_error(b_err)
    );

    // Reference model: per-DUT staging and live arrays plus the stream pointer.
    logic [7:0] stage_m [2][16];
    logic [7:0] live_m  [2][16];
    int         ptr_m   [2];

    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_evt;
    logic       last_err;
    logic [7:0] obs_rd_commit, obs_rd_after;

    function automatic int nregs(input int w);
        return (w == 0) ? NR_A : NR_B;
    endfunction

    function automatic logic [NR_A*8-1:0] exp_a();
        logic [NR_A*8-1:0] v;
        for (int i = 0; i < NR_A; i++) v[8*i +: 8] = live_m[0][i];
        return v;
    endfunction

    function automatic logic [NR_B*8-1:0] exp_b();
        logic [NR_B*8-1:0] v;
        for (int i = 0; i < NR_B; i++) v[8*i +: 8] = live_m[1][i];
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int w, input int addr);
        return (addr < nregs(w)) ? live_m[w][addr] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            ptr_m[w] = 0;
            for (int i = 0; i < 16; i++) begin
                stage_m[w][i] = 8'h00;
                live_m[w][i]  = 8'h00;
            end
        end
    endtask

    task automatic model_apply(input int w, input int ea, input logic [7:0] data, input logic str,
                               output logic [3:0] evt, output logic err);
        int base;
        evt = '0;
        err = 1'b0;
        if (ea >= nregs(w)) begin
            err = 1'b1;
            return;
        end
        stage_m[w][ea] = data;
        if (ea % BR == BR - 1) begin
            base = ea - (BR - 1);
            for (int k = 0; k < BR; k++) live_m[w][base + k] = stage_m[w][base + k];
            evt[ea / BR] = 1'b1;
        end
        if (str) ptr_m[w] = (ptr_m[w] + 1) % nregs(w);
    endtask

    // One UART write: caller is 1 time unit after an edge with ready already sampled low.
    task automatic do_write(input int w, input int addr, input logic [7:0] data);
        logic       str;
        int         ea, rda;
        logic [3:0] exp_evt, got_evt;
        logic       exp_err, got_err;
        logic [7:0] rd_pre, got_rd;
        str    = (w == 0) ? a_stream : b_stream;
        rda    = (w == 0) ? int'(a_rd) : int'(b_rd);
        rd_pre = exp_rd(w, rda);
        ea     = str ? ptr_m[w] : addr;
        model_apply(w, ea, data, str, exp_evt, exp_err);
        if (w == 0) begin a_rdy = 1'b1; a_addr = AW'(addr); a_data = data; end
        else        begin b_rdy = 1'b1; b_addr = AW'(addr); b_data = data; end
        @(posedge clk);
        @(posedge clk);
        #1;
        got_evt  = (w == 0) ? a_evt : {1'b0, b_evt};
        got_err  = (w == 0) ? a_err : b_err;
        got_rd   = (w == 0) ? a_rdd : b_rdd;
        last_evt = got_evt;
        last_err = got_err;
        obs_rd_commit = got_rd;
        checks++;
        if (got_evt !== exp_evt) begin
            errors++;
            $display("FAIL write_event dut%0d addr %0d: got %b expected %b", w, ea, got_evt, exp_evt);
        end
        checks++;
        if (got_err !== exp_err) begin
            errors++;
            $display("FAIL write_addr_error dut%0d addr %0d: got %b expected %b", w, ea, got_err, exp_err);
        end
        checks++;
        if (got_rd !== rd_pre) begin
            errors++;
            $display("FAIL rd_at_commit dut%0d rd_addr %0d: got %h expected %h", w, rda, got_rd, rd_pre);
        end
        checks++;
        if (w == 0 && a_reg !== exp_a()) begin
            errors++;
            $display("FAIL reg_data dut0 after addr %0d: got %h expected %h", ea, a_reg, exp_a());
        end else if (w == 1 && b_reg !== exp_b()) begin
            errors++;
            $display("FAIL reg_data dut1 after addr %0d: got %h expected %h", ea, b_reg, exp_b());
        end
        if (w == 0) a_rdy = 1'b0; else b_rdy = 1'b0;
        @(posedge clk);
        #1;
        got_evt = (w == 0) ? a_evt : {1'b0, b_evt};
        got_err = (w == 0) ? a_err : b_err;
        got_rd  = (w == 0) ? a_rdd : b_rdd;
        obs_rd_after = got_rd;
        checks++;
        if (got_evt !== 4'b0000 || got_err !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width dut%0d: event %b error %b, expected 0000 0", w, got_evt, got_err);
        end
        checks++;
        if (got_rd !== exp_rd(w, rda)) begin
            errors++;
            $display("FAIL rd_after dut%0d rd_addr %0d: got %h expected %h", w, rda, got_rd, exp_rd(w, rda));
        end
    endtask

    // Asserts reset mid-run, checks the held state, releases and checks event clear.
    task automatic reset_and_check(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (a_evt !== 4'b1111 || b_evt !== 3'b111) begin
            errors++;
            $display("FAIL %s event_in_reset: got %b/%b expected 1111/111", tag, a_evt, b_evt);
        end
        checks++;
        if (a_reg !== '0 || b_reg !== '0) begin
            errors++;
            $display("FAIL %s reg_data_in_reset: got %h / %h expected 0", tag, a_reg, b_reg);
        end
        checks++;
        if (a_rdd !== 8'h00 || a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_err_in_reset: got rd %h err %b/%b expected 00 0/0", tag, a_rdd, a_err, b_err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (a_evt !== 4'b0000 || b_evt !== 3'b000) begin
            errors++;
            $display("FAIL %s event_after_release: got %b/%b expected 0000/000", tag, a_evt, b_evt);
        end
    endtask

    task automatic test_reset();
        a_rdy = 1'b1; a_addr = 4'd3; a_data = 8'hAA;
        b_rdy = 1'b1; b_addr = 4'd3; b_data = 8'hBB;
        reset_and_check("reset");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_evt !== 4'b0000 || b_evt !== 3'b000 || a_reg !== '0 || b_reg !== '0) begin
                errors++;
                $display("FAIL ready_high_at_release cycle %0d: event %b/%b reg %h", c, a_evt, b_evt, a_reg);
            end
        end
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bank_commit();
        a_rd = 4'd7;
        do_write(0, 4, 8'h11);
        do_write(0, 5, 8'h22);
        do_write(0, 6, 8'h33);
        checks++;
        if (a_reg !== '0) begin
            errors++;
            $display("FAIL staged_not_live: got %h expected 0", a_reg);
        end
        do_write(0, 7, 8'h44);
        checks++;
        if (a_reg[63:32] !== 32'h44332211 || last_evt !== 4'b0010) begin
            errors++;
            $display("FAIL bank1_commit: bytes %h event %b expected 44332211 0010", a_reg[63:32], last_evt);
        end
        checks++;
        if (obs_rd_commit !== 8'h00 || obs_rd_after !== 8'h44) begin
            errors++;
            $display("FAIL readback_across_commit: got %h then %h expected 00 then 44", obs_rd_commit, obs_rd_after);
        end
    endtask

    task automatic test_stream();
        logic [3:0] seen[$];
        a_stream = 1'b1;
        a_rd     = 4'd0;
        for (int n = 1; n <= 17; n++) begin
            do_write(0, $urandom_range(0, 15), 8'(n));
            if (last_evt != 4'b0000) seen.push_back(last_evt);
        end
        checks++;
        if (seen.size() != 4 || seen[0] !== 4'b0001 || seen[1] !== 4'b0010 ||
            seen[2] !== 4'b0100 || seen[3] !== 4'b1000) begin
            errors++;
            $display("FAIL stream_event_order: got %0d events, first %b", seen.size(),
                     (seen.size() > 0) ? seen[0] : 4'b0000);
        end
        checks++;
        if (a_reg[7:0] !== 8'h01 || a_rdd !== 8'h01) begin
            errors++;
            $display("FAIL stream_wrap_live: reg0 %h rd %h expected 01 01", a_reg[7:0], a_rdd);
        end
        a_stream = 1'b0;
        ptr_m[0] = 0;
        do_write(0, 3, 8'h33);
        checks++;
        if (a_reg[7:0] !== 8'h11) begin
            errors++;
            $display("FAIL stream_wrap_staged: reg0 %h expected 11", a_reg[7:0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_stream = ~a_stream;
                if (!a_stream) ptr_m[0] = 0;
            end
            a_rd = AW'($urandom_range(0, 15));
            do_write(0, $urandom_range(0, 15), 8'($urandom));
        end
        a_stream = 1'b0;
        ptr_m[0] = 0;
    endtask

    task automatic test_addr_error();
        b_rd = 4'd14;
        do_write(1, 0, 8'($urandom));
        do_write(1, 1, 8'($urandom));
        do_write(1, 13, 8'hEE);
        checks++;
        if (last_err !== 1'b1 || b_rdd !== 8'h00) begin
            errors++;
            $display("FAIL out_of_range_write: error %b rd %h expected 1 00", last_err, b_rdd);
        end
        b_rd = 4'd2;
        do_write(1, 2, 8'($urandom));
        do_write(1, 15, 8'h5C);
        b_rd = 4'd3;
        do_write(1, 3, 8'($urandom));
        for (int n = 0; n < 12; n++) begin
            b_rd = AW'($urandom_range(0, 15));
            do_write(1, $urandom_range(0, 15), 8'($urandom));
        end
    endtask

    task automatic test_held_ready();
        logic [3:0] dummy_evt;
        logic       dummy_err;
        int         pulses = 0;
        model_apply(0, 11, 8'h5A, 1'b0, dummy_evt, dummy_err);
        a_rdy = 1'b1; a_addr = 4'd11; a_data = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (a_evt != 4'b0000) pulses++;
        end
        checks++;
        if (pulses != 1 || a_reg !== exp_a()) begin
            errors++;
            $display("FAIL held_ready: %0d pulses reg %h expected 1 pulse reg %h", pulses, a_reg, exp_a());
        end
        a_rdy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_bank();
        do_write(0, 8, 8'h81);
        do_write(0, 9, 8'h92);
        reset_and_check("mid_bank");
        do_write(0, 11, 8'h77);
        checks++;
        if (a_reg[95:64] !== 32'h77000000) begin
            errors++;
            $display("FAIL mid_bank_discard: bank2 %h expected 77000000", a_reg[95:64]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        a_addr   = '0; b_addr = '0; a_rd = '0; b_rd = '0;
        a_data   = '0; b_data = '0;
        a_rdy    = 1'b0; b_rdy = 1'b0;
        a_stream = 1'b0; b_stream = 1'b0;
        model_reset();
        test_reset();
        test_bank_commit();
        test_stream();
        test_random();
        test_addr_error();
        test_held_ready();
        test_reset_mid_bank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
